rollback_sequencer: RTL and testbench



---
 rtl/rollback_sequencer_pkg.sv | 45 ++++
 rtl/rollback_sequencer_age_picker.sv | 37 +++
 rtl/rollback_sequencer.sv | 175 +++++++++++++++++
 tb/tb_rollback_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rollback_sequencer_pkg.sv
// Shared types and constants for the rollback sequencer and its age picker.
package rollback_sequencer_pkg;

  // Default sizing; the request struct below is built from these widths.
  localparam int RB_NUM_ROB = 32;
  localparam int RB_NUM_FL  = 32;
  localparam int RB_NUM_LSQ = 8;
  localparam int RB_NUM_REQ = 4;
  localparam int RB_RW      = $clog2(RB_NUM_ROB);
  localparam int RB_FW      = $clog2(RB_NUM_FL);
  localparam int RB_QW      = $clog2(RB_NUM_LSQ);
  localparam int RB_SW      = $clog2(RB_NUM_REQ);
  localparam int RB_PCW     = 64;

  // Requester IDs: two branch units followed by two load-queue ports.
  localparam logic [RB_SW-1:0] SRC_BR0 = RB_SW'(0);
  localparam logic [RB_SW-1:0] SRC_BR1 = RB_SW'(1);
  localparam logic [RB_SW-1:0] SRC_LQ0 = RB_SW'(2);
  localparam logic [RB_SW-1:0] SRC_LQ1 = RB_SW'(3);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SQUASH   = 2'd1,
    ST_WALK     = 2'd2,
    ST_REDIRECT = 2'd3
  } rb_state_e;

  // Everything needed to recover from one rollback request.
  typedef struct packed {
    logic [RB_RW-1:0]  rob_idx;
    logic [RB_FW-1:0]  fl_idx;
    logic [RB_QW-1:0]  sq_idx;
    logic [RB_QW-1:0]  lq_idx;
    logic [RB_PCW-1:0] target_pc;
  } rb_req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic is_branch_src(input logic [RB_SW-1:0] src);
    return (src == SRC_BR0) || (src == SRC_BR1);
  endfunction

endpackage

// File: rtl/rollback_sequencer_age_picker.sv
// Combinational oldest-of-N select. Age is the RW-bit modular distance from
// the reference tail back to the request's ROB index; larger is older and a
// tie keeps the lower source index.
module rollback_age_picker
  import rollback_sequencer_pkg::*;
#(
  parameter int NUM_REQ = RB_NUM_REQ,
  parameter int RW      = RB_RW,
  localparam int SW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [NUM_REQ-1:0][RW-1:0] rob_idx,
  input  logic [RW-1:0]              ref_tail,
  output logic [SW-1:0]              win_idx,
  output logic [RW-1:0]              win_age,
  output logic                       any_valid
);

  logic [RW-1:0] age;

  // Linear scan; strict '>' leaves the earlier (lower) source on ties.
  always_comb begin
    win_idx   = '0;
    win_age   = '0;
    any_valid = 1'b0;
    age       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      age = ref_tail - rob_idx[i];
      if (valid[i] && (!any_valid || (age > win_age))) begin
        win_idx   = SW'(i);
        win_age   = age;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rollback_sequencer.sv
// Rollback sequencer: picks the oldest rollback request, pulses a squash,
// holds fetch stalled through the ROB walk, then offers a redirect.
// Redirect handshake: redirect_valid/redirect_PC are held stable from the
// cycle they rise until the cycle fetch_ready is sampled high with them; the
// transfer happens on that edge unless an older request preempts it.
module rollback_sequencer
  import rollback_sequencer_pkg::*;
#(
  parameter int NUM_ROB = RB_NUM_ROB,
  parameter int NUM_FL  = RB_NUM_FL,
  parameter int NUM_LSQ = RB_NUM_LSQ,
  parameter int NUM_REQ = RB_NUM_REQ,
  localparam int RW     = $clog2(NUM_ROB),
  localparam int FW     = $clog2(NUM_FL),
  localparam int QW     = $clog2(NUM_LSQ),
  localparam int SW     = $clog2(NUM_REQ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0][RW-1:0]   req_ROB_idx,
  input  logic [NUM_REQ-1:0][FW-1:0]   req_FL_idx,
  input  logic [NUM_REQ-1:0][QW-1:0]   req_SQ_idx,
  input  logic [NUM_REQ-1:0][QW-1:0]   req_LQ_idx,
  input  logic [NUM_REQ-1:0][63:0]     req_target_PC,
  input  logic [RW-1:0]                ROB_tail_idx,
  input  logic                         rob_walk_done,
  input  logic                         fetch_ready,
  output logic                         rollback_en,
  output logic [RW-1:0]                ROB_rollback_idx,
  output logic [FW-1:0]                FL_rollback_idx,
  output logic [QW-1:0]                SQ_rollback_idx,
  output logic [QW-1:0]                LQ_rollback_idx,
  output logic                         stall_fetch,
  output logic                         redirect_valid,
  output logic [63:0]                  redirect_PC,
  output logic                         pred_update_en,
  output logic                         pred_update_sel,
  output logic                         busy,
  output logic [15:0]                  rollback_count,
  output logic [15:0]                  drop_count,
  output rb_state_e                    state_dbg
);

  rb_state_e     state;
  rb_req_t       req_arr [NUM_REQ];
  rb_req_t       win_req;
  logic [63:0]   lat_pc;
  logic [RW-1:0] ref_tail;
  logic [RW-1:0] lat_age;
  logic [RW-1:0] pick_ref;
  logic [RW-1:0] win_age;
  logic [RW-1:0] drop_age;
  logic [SW-1:0] win_idx;
  logic          any_valid;
  logic          preempt;
  logic          take;
  logic          drop_any;

  assign state_dbg = state;

  // Gather per-source request fields into records.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_arr[i] = '{rob_idx:   req_ROB_idx[i],
                     fl_idx:    req_FL_idx[i],
                     sq_idx:    req_SQ_idx[i],
                     lq_idx:    req_LQ_idx[i],
                     target_pc: req_target_PC[i]};
    end
  end

  // Live tail while idle; frozen episode tail otherwise, so the latched age
  // and any challenger are measured against the same reference.
  assign pick_ref = (state == ST_IDLE) ? ROB_tail_idx : ref_tail;

  rollback_age_picker #(
    .NUM_REQ (NUM_REQ),
    .RW      (RW)
  ) u_picker (
    .valid     (req_valid),
    .rob_idx   (req_ROB_idx),
    .ref_tail  (pick_ref),
    .win_idx   (win_idx),
    .win_age   (win_age),
    .any_valid (any_valid)
  );

  assign win_req = req_arr[win_idx];
  assign preempt = (state != ST_IDLE) && any_valid && (win_age > lat_age);
  assign take    = (state == ST_IDLE) ? any_valid : preempt;

  // Mid-episode, any request no older than the one in flight is discarded.
  always_comb begin
    drop_any = 1'b0;
    drop_age = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      drop_age = ref_tail - req_ROB_idx[i];
      if (req_valid[i] && (drop_age <= lat_age)) drop_any = 1'b1;
    end
  end

  // Episode FSM with registered outputs; an accepted or preempting request
  // always restarts at SQUASH and takes priority over walk_done/fetch_ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_IDLE;
      lat_pc           <= '0;
      ref_tail         <= '0;
      lat_age          <= '0;
      rollback_en      <= 1'b0;
      ROB_rollback_idx <= '0;
      FL_rollback_idx  <= '0;
      SQ_rollback_idx  <= '0;
      LQ_rollback_idx  <= '0;
      stall_fetch      <= 1'b0;
      busy             <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_PC      <= '0;
      pred_update_en   <= 1'b0;
      pred_update_sel  <= 1'b0;
      rollback_count   <= '0;
      drop_count       <= '0;
    end else begin
      rollback_en      <= 1'b0;
      ROB_rollback_idx <= '0;
      FL_rollback_idx  <= '0;
      SQ_rollback_idx  <= '0;
      LQ_rollback_idx  <= '0;
      pred_update_en   <= 1'b0;
      pred_update_sel  <= 1'b0;
      if ((state != ST_IDLE) && drop_any) drop_count <= sat_inc16(drop_count);
      if (take) begin
        state            <= ST_SQUASH;
        lat_pc           <= win_req.target_pc;
        ref_tail         <= pick_ref;
        lat_age          <= win_age;
        rollback_en      <= 1'b1;
        ROB_rollback_idx <= win_req.rob_idx;
        FL_rollback_idx  <= win_req.fl_idx;
        SQ_rollback_idx  <= win_req.sq_idx;
        LQ_rollback_idx  <= win_req.lq_idx;
        pred_update_en   <= is_branch_src(win_idx);
        pred_update_sel  <= is_branch_src(win_idx) && win_idx[0];
        rollback_count   <= sat_inc16(rollback_count);
        stall_fetch      <= 1'b1;
        busy             <= 1'b1;
        redirect_valid   <= 1'b0;
        redirect_PC      <= '0;
      end else begin
        case (state)
          ST_SQUASH: state <= ST_WALK;
          ST_WALK: begin
            if (rob_walk_done) begin
              state          <= ST_REDIRECT;
              redirect_valid <= 1'b1;
              redirect_PC    <= lat_pc;
            end
          end
          ST_REDIRECT: begin
            if (fetch_ready) begin
              state          <= ST_IDLE;
              redirect_valid <= 1'b0;
              redirect_PC    <= '0;
              stall_fetch    <= 1'b0;
              busy           <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rollback_sequencer.sv
// Bench for rollback_sequencer: reset check, hand-written episode sequences,
// a table of oldest-select vectors, then random traffic against a cycle model.
module tb_rollback_sequencer;
  import rollback_sequencer_pkg::*;

  localparam int NR   = 4;
  localparam int RW   = 5;
  localparam int FW   = 5;
  localparam int QW   = 3;
  localparam int NROB = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NR-1:0]          req_valid;
  logic [NR-1:0][RW-1:0]  req_ROB_idx;
  logic [NR-1:0][FW-1:0]  req_FL_idx;
  logic [NR-1:0][QW-1:0]  req_SQ_idx;
  logic [NR-1:0][QW-1:0]  req_LQ_idx;
  logic [NR-1:0][63:0]    req_target_PC;
  logic [RW-1:0]          ROB_tail_idx;
  logic                   rob_walk_done;
  logic                   fetch_ready;
  logic                   rollback_en;
  logic [RW-1:0]          ROB_rollback_idx;
  logic [FW-1:0]          FL_rollback_idx;
  logic [QW-1:0]          SQ_rollback_idx;
  logic [QW-1:0]          LQ_rollback_idx;
  logic                   stall_fetch;
  logic                   redirect_valid;
  logic [63:0]            redirect_PC;
  logic                   pred_update_en;
  logic                   pred_update_sel;
  logic                   busy;
  logic [15:0]            rollback_count;
  logic [15:0]            drop_count;
  rb_state_e              state_dbg;

  rollback_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ROB_idx      (req_ROB_idx),
    .req_FL_idx       (req_FL_idx),
    .req_SQ_idx       (req_SQ_idx),
    .req_LQ_idx       (req_LQ_idx),
    .req_target_PC    (req_target_PC),
    .ROB_tail_idx     (ROB_tail_idx),
    .rob_walk_done    (rob_walk_done),
    .fetch_ready      (fetch_ready),
    .rollback_en      (rollback_en),
    .ROB_rollback_idx (ROB_rollback_idx),
    .FL_rollback_idx  (FL_rollback_idx),
    .SQ_rollback_idx  (SQ_rollback_idx),
    .LQ_rollback_idx  (LQ_rollback_idx),
    .stall_fetch      (stall_fetch),
    .redirect_valid   (redirect_valid),
    .redirect_PC      (redirect_PC),
    .pred_update_en   (pred_update_en),
    .pred_update_sel  (pred_update_sel),
    .busy             (busy),
    .rollback_count   (rollback_count),
    .drop_count       (drop_count),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Episode phase: 0 idle, 1 squash, 2 walk, 3 redirect.
  int          m_mode, m_ref, m_age;
  logic [63:0] m_pc;
  logic        e_rb, e_rv, e_pu, e_sel;
  logic [RW-1:0] e_rob;
  logic [FW-1:0] e_fl;
  logic [QW-1:0] e_sq, e_lq;
  logic [63:0]   e_pc;
  logic [15:0]   e_rc, e_dc;

  task automatic model_step();
    int rf, best, bage, a;
    bit drop;
    if (reset) begin
      m_mode = 0; m_ref = 0; m_age = 0; m_pc = '0;
      e_rb = 0; e_rv = 0; e_pu = 0; e_sel = 0;
      e_rob = '0; e_fl = '0; e_sq = '0; e_lq = '0; e_pc = '0;
      e_rc = '0; e_dc = '0;
      return;
    end
    e_rb = 0; e_pu = 0; e_sel = 0;
    e_rob = '0; e_fl = '0; e_sq = '0; e_lq = '0;
    rf   = (m_mode == 0) ? int'(ROB_tail_idx) : m_ref;
    best = -1; bage = -1; drop = 0;
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i]) begin
        a = (rf - int'(req_ROB_idx[i]) + NROB) % NROB;
        if (a > bage) begin best = i; bage = a; end
        if (m_mode != 0 && a <= m_age) drop = 1;
      end
    end
    if (drop && e_dc != 16'hFFFF) e_dc = e_dc + 16'd1;
    if (best >= 0 && (m_mode == 0 || bage > m_age)) begin
      m_mode = 1; m_ref = rf; m_age = bage; m_pc = req_target_PC[best];
      e_rb = 1; e_rob = req_ROB_idx[best]; e_fl = req_FL_idx[best];
      e_sq = req_SQ_idx[best]; e_lq = req_LQ_idx[best];
      e_pu = (best < 2); e_sel = (best == 1);
      if (e_rc != 16'hFFFF) e_rc = e_rc + 16'd1;
      e_rv = 0; e_pc = '0;
    end else if (m_mode == 1) begin
      m_mode = 2;
    end else if (m_mode == 2 && rob_walk_done) begin
      m_mode = 3; e_rv = 1; e_pc = m_pc;
    end else if (m_mode == 3 && fetch_ready) begin
      m_mode = 0; e_rv = 0; e_pc = '0;
    end
  endtask

  // One clock: predict, advance, compare every output against the model.
  task automatic tick();
    logic [127:0] act_vec, exp_vec;
    model_step();
    exp_q.push_back({10'd0, e_rb, e_rob, e_fl, e_sq, e_lq, (m_mode != 0), (m_mode != 0),
                     e_rv, e_pc, e_pu, e_sel, e_rc, e_dc});
    @(posedge clock);
    #1;
    act_vec = {10'd0, rollback_en, ROB_rollback_idx, FL_rollback_idx, SQ_rollback_idx,
               LQ_rollback_idx, stall_fetch, busy, redirect_valid, redirect_PC,
               pred_update_en, pred_update_sel, rollback_count, drop_count};
    exp_vec = exp_q.pop_front();
    n_checks++;
    if (act_vec !== exp_vec) begin
      n_errors++;
      $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act_vec, exp_vec);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_req();
    req_valid = '0; req_ROB_idx = '0; req_FL_idx = '0;
    req_SQ_idx = '0; req_LQ_idx = '0; req_target_PC = '0;
  endtask

  task automatic set_req(input int i, input logic [RW-1:0] rob, input logic [FW-1:0] fl,
                         input logic [QW-1:0] sq, input logic [QW-1:0] lq, input logic [63:0] pc);
    req_valid[i] = 1'b1; req_ROB_idx[i] = rob; req_FL_idx[i] = fl;
    req_SQ_idx[i] = sq; req_LQ_idx[i] = lq; req_target_PC[i] = pc;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]         valid;
    logic [3:0][RW-1:0] rob;     // {req3, req2, req1, req0}
    logic [RW-1:0]      tail;
    int                 exp_src;
    logic               exp_pred;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int s;
    vecs[0] = '{valid: 4'b0001, rob: {5'd0, 5'd0, 5'd0, 5'd5},    tail: 5'd10, exp_src: 0, exp_pred: 1'b1};
    vecs[1] = '{valid: 4'b1111, rob: {5'd28, 5'd28, 5'd1, 5'd30}, tail: 5'd3,  exp_src: 2, exp_pred: 1'b0};
    vecs[2] = '{valid: 4'b0011, rob: {5'd0, 5'd0, 5'd1, 5'd31},   tail: 5'd0,  exp_src: 1, exp_pred: 1'b1};
    vecs[3] = '{valid: 4'b1111, rob: {5'd7, 5'd7, 5'd7, 5'd7},    tail: 5'd9,  exp_src: 0, exp_pred: 1'b1};
    vecs[4] = '{valid: 4'b1000, rob: {5'd20, 5'd0, 5'd0, 5'd0},   tail: 5'd20, exp_src: 3, exp_pred: 1'b0};
    vecs[5] = '{valid: 4'b1010, rob: {5'd0, 5'd0, 5'd15, 5'd0},   tail: 5'd16, exp_src: 3, exp_pred: 1'b0};
    vecs[6] = '{valid: 4'b0110, rob: {5'd0, 5'd4, 5'd4, 5'd0},    tail: 5'd4,  exp_src: 1, exp_pred: 1'b1};

    clear_req();
    ROB_tail_idx = '0; rob_walk_done = 1'b0; fetch_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    check("reset_rb_en", 64'(rollback_en), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    reset = 1'b0;
    tick();

    // Single branch, walk takes 3 cycles, fetch_ready held low 5 cycles.
    ROB_tail_idx = 5'd10;
    set_req(0, 5'd5, 5'd3, 3'd2, 3'd4, 64'hABCD_0000);
    tick();
    check("br_rb_en", 64'(rollback_en), 64'd1);
    check("br_rob_idx", 64'(ROB_rollback_idx), 64'd5);
    check("br_fl_idx", 64'(FL_rollback_idx), 64'd3);
    check("br_pred_en", 64'(pred_update_en), 64'd1);
    check("br_pred_sel", 64'(pred_update_sel), 64'd0);
    check("br_rcount", 64'(rollback_count), 64'd1);
    clear_req();
    tick();
    check("br_walk_rb_en", 64'(rollback_en), 64'd0);
    check("br_walk_state", 64'(state_dbg), 64'(ST_WALK));
    tick(); tick();
    rob_walk_done = 1'b1; tick(); rob_walk_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("hold_rv", 64'(redirect_valid), 64'd1);
      check("hold_pc", redirect_PC, 64'hABCD_0000);
      tick();
    end
    check("hold_rv_last", 64'(redirect_valid), 64'd1);
    fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
    check("br_done_busy", 64'(busy), 64'd0);
    check("br_done_rv", 64'(redirect_valid), 64'd0);

    // Preempt in WALK, with a younger request dropped first.
    ROB_tail_idx = 5'd12;
    set_req(0, 5'd8, 5'd1, 3'd1, 3'd1, 64'h8000_0000);
    tick(); clear_req(); tick();
    set_req(3, 5'd10, 5'd2, 3'd2, 3'd2, 64'hDEAD_0000);
    tick(); clear_req();
    check("drop_state", 64'(state_dbg), 64'(ST_WALK));
    check("drop_count", 64'(drop_count), 64'd1);
    check("drop_rb_en", 64'(rollback_en), 64'd0);
    set_req(1, 5'd6, 5'd9, 3'd3, 3'd5, 64'h9000_0040);
    tick(); clear_req();
    check("pre_rb_en", 64'(rollback_en), 64'd1);
    check("pre_rob_idx", 64'(ROB_rollback_idx), 64'd6);
    check("pre_fl_idx", 64'(FL_rollback_idx), 64'd9);
    check("pre_pred_sel", 64'(pred_update_sel), 64'd1);
    check("pre_rcount", 64'(rollback_count), 64'd3);
    tick();
    rob_walk_done = 1'b1; tick(); rob_walk_done = 1'b0;
    check("pre_redir_pc", redirect_PC, 64'h9000_0040);
    fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
    check("pre_idle", 64'(state_dbg), 64'(ST_IDLE));

    // Older request during the REDIRECT->IDLE handoff wins over fetch_ready.
    ROB_tail_idx = 5'd20;
    set_req(2, 5'd15, 5'd4, 3'd4, 3'd4, 64'h2222);
    tick(); clear_req(); tick();
    rob_walk_done = 1'b1; tick(); rob_walk_done = 1'b0;
    check("ho_rv", 64'(redirect_valid), 64'd1);
    fetch_ready = 1'b1;
    set_req(0, 5'd10, 5'd6, 3'd6, 3'd6, 64'h3333);
    tick(); clear_req(); fetch_ready = 1'b0;
    check("ho_state", 64'(state_dbg), 64'(ST_SQUASH));
    check("ho_rv_drop", 64'(redirect_valid), 64'd0);
    check("ho_rob_idx", 64'(ROB_rollback_idx), 64'd10);
    check("ho_rcount", 64'(rollback_count), 64'd5);
    tick();
    rob_walk_done = 1'b1; tick(); rob_walk_done = 1'b0;
    check("ho_pc", redirect_PC, 64'h3333);
    fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;

    // Reset during WALK aborts the episode with no redirect.
    ROB_tail_idx = 5'd2;
    set_req(0, 5'd1, 5'd1, 3'd1, 3'd1, 64'h4444);
    tick(); clear_req(); tick();
    reset = 1'b1; tick();
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rcount", 64'(rollback_count), 64'd0);
    reset = 1'b0;
    rob_walk_done = 1'b1; fetch_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_no_redirect", 64'(redirect_valid), 64'd0);
    end
    rob_walk_done = 1'b0; fetch_ready = 1'b0;

    // Table of oldest-select vectors, each run as a full minimum episode.
    for (int k = 0; k < 7; k++) begin
      clear_req();
      ROB_tail_idx = vecs[k].tail;
      for (int i = 0; i < NR; i++)
        if (vecs[k].valid[i])
          set_req(i, vecs[k].rob[i], 5'(i + 1), 3'(i), 3'(7 - i), 64'h1000 + 64'(i * 16));
      tick();
      s = vecs[k].exp_src;
      check("tbl_rb_en", 64'(rollback_en), 64'd1);
      check("tbl_rob_idx", 64'(ROB_rollback_idx), 64'(vecs[k].rob[s]));
      check("tbl_fl_idx", 64'(FL_rollback_idx), 64'(s + 1));
      check("tbl_lq_idx", 64'(LQ_rollback_idx), 64'(7 - s));
      check("tbl_pred_en", 64'(pred_update_en), 64'(vecs[k].exp_pred));
      check("tbl_pred_sel", 64'(pred_update_sel), 64'(s == 1));
      check("tbl_rcount", 64'(rollback_count), 64'(k + 1));
      clear_req(); tick();
      rob_walk_done = 1'b1; tick(); rob_walk_done = 1'b0;
      check("tbl_redir_pc", redirect_PC, 64'h1000 + 64'(s * 16));
      fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
      check("tbl_idle", 64'(busy), 64'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      ROB_tail_idx = 5'($urandom_range(0, 31));
      for (int i = 0; i < NR; i++) begin
        req_valid[i]     = ($urandom_range(0, 9) == 0);
        req_ROB_idx[i]   = 5'($urandom_range(0, 31));
        req_FL_idx[i]    = 5'($urandom_range(0, 31));
        req_SQ_idx[i]    = 3'($urandom_range(0, 7));
        req_LQ_idx[i]    = 3'($urandom_range(0, 7));
        req_target_PC[i] = {$urandom, $urandom};
      end
      rob_walk_done = ($urandom_range(0, 3) == 0);
      fetch_ready   = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
